// File: rtl/thread_writeback.sv
// thread_writeback: writeback and thread-control stage behind the execute ALU
// of the 4-thread barrel pipeline.
//   - Commits ALU results and queued LSU load results to the register-file
//     write port (rf_*). ALU has fixed priority; LSU results wait in a small FIFO.
//   - Holds one PC per thread, updated from alu_new_pc on every legal commit.
//   - Runs a per-thread FSM (OFF/READY/ISSUED/WAIT_MEM/HALT) and offers the
//     next READY thread's PC to fetch in round-robin order.
// Ports:
//   clk, rst (async, active low)
//   thread_enable           per-thread run request
//   alu_*                   ALU commit (never stalled)
//   lsu_valid/lsu_ready/... load results into the writeback FIFO
//   rf_we/waddr/wdata/wtid  registered register-file write port
//   fetch_valid/ready/pc/tid registered fetch offer
//   halted                  threads stopped on an illegal instruction

// Per-thread state machine and PC register.
module thread_ctl #(
  parameter int          PC_W     = 29,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            offered,     // this thread is the current fetch offer
  input  logic            grant,       // fetch handshake for this thread
  input  logic            alu_sel,     // alu_valid with alu_tid == this thread
  input  logic            alu_pend,
  input  logic            alu_illegal,
  input  logic [PC_W-1:0] alu_new_pc,
  input  logic            lsu_rel,     // this thread's LSU entry drains this cycle
  output logic            ready,
  output logic            issued,
  output logic            halt,
  output logic [PC_W-1:0] pc
);
  typedef enum logic [2:0] {OFF, READY, ISSUED, WAIT_MEM, HALT} state_t;
  state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OFF;
      pc    <= RESET_PC;
    end else begin
      case (state)
        OFF:      if (enable) state <= READY;
        // An offered thread must stay READY until taken so the offer stays stable.
        READY:    if (grant) state <= ISSUED;
                  else if (!enable && !offered) state <= OFF;
        ISSUED:   if (alu_sel) begin
                    if (alu_illegal) state <= HALT;
                    else begin
                      pc    <= alu_new_pc;
                      state <= alu_pend ? WAIT_MEM : READY;
                    end
                  end
        WAIT_MEM: if (lsu_rel) state <= READY;
        HALT:     state <= HALT;
        default:  state <= OFF;
      endcase
    end
  end

  assign ready  = (state == READY);
  assign issued = (state == ISSUED);
  assign halt   = (state == HALT);
endmodule

module thread_writeback #(
  parameter int          XLEN      = 32,
  parameter int          THREADS   = 4,
  parameter int          TID_W     = 2,
  parameter int          PC_W      = 29,
  parameter logic [PC_W-1:0] RESET_PC = 29'h0,
  parameter int          LSU_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [THREADS-1:0]  thread_enable,
  input  logic                alu_valid,
  input  logic                alu_rd_en,
  input  logic [4:0]          alu_rd_addr,
  input  logic [XLEN-1:0]     alu_rd_data,
  input  logic [TID_W-1:0]    alu_tid,
  input  logic [PC_W-1:0]     alu_new_pc,
  input  logic                alu_lsu_pend,
  input  logic                alu_illegal,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [4:0]          lsu_rd_addr,
  input  logic [XLEN-1:0]     lsu_rd_data,
  input  logic [TID_W-1:0]    lsu_tid,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [TID_W-1:0]    rf_wtid,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output logic [PC_W-1:0]     fetch_pc,
  output logic [TID_W-1:0]    fetch_tid,
  output logic [THREADS-1:0]  halted
);
  localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
  localparam int CW = $clog2(LSU_DEPTH + 1);

  typedef struct packed {
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
    logic [TID_W-1:0] tid;
  } lsu_ent_t;

  logic [THREADS-1:0]           t_ready, t_issued, t_halt;
  logic [THREADS-1:0][PC_W-1:0] t_pc;
  logic [THREADS-1:0]           grant_vec, offer_vec, alu_sel_vec, lsu_rel_vec;

  logic grant, alu_accept, alu_claim;
  assign grant      = fetch_valid & fetch_ready;
  // Commits for threads not in ISSUED are protocol errors and are dropped.
  assign alu_accept = alu_valid & t_issued[alu_tid];
  assign alu_claim  = alu_accept & alu_rd_en & ~alu_illegal & (alu_rd_addr != 5'd0);

  // ---------------- LSU writeback FIFO ----------------
  lsu_ent_t          fifo_q [LSU_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              full, empty, enq, drain;
  lsu_ent_t          head;

  assign full      = (count == CW'(LSU_DEPTH));
  assign empty     = (count == '0);
  assign lsu_ready = ~full;
  assign enq       = lsu_valid & ~full;
  assign drain     = ~empty & ~alu_claim;
  assign head      = fifo_q[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(LSU_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LSU_DEPTH; i++) fifo_q[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        fifo_q[wr_ptr] <= '{rd: lsu_rd_addr, data: lsu_rd_data, tid: lsu_tid};
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (drain) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- register-file write port ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_wtid  <= '0;
    end else if (alu_claim) begin
      rf_we    <= 1'b1;
      rf_waddr <= alu_rd_addr;
      rf_wdata <= alu_rd_data;
      rf_wtid  <= alu_tid;
    end else if (drain) begin
      // rd=0 loads still drain (and release WAIT_MEM) but write nothing.
      rf_we    <= (head.rd != 5'd0);
      rf_waddr <= head.rd;
      rf_wdata <= head.data;
      rf_wtid  <= head.tid;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // ---------------- per-thread control ----------------
  for (genvar t = 0; t < THREADS; t++) begin : g_thr
    assign offer_vec[t]   = fetch_valid & (fetch_tid == TID_W'(t));
    assign grant_vec[t]   = grant & (fetch_tid == TID_W'(t));
    assign alu_sel_vec[t] = alu_valid & (alu_tid == TID_W'(t));
    assign lsu_rel_vec[t] = drain & (head.tid == TID_W'(t));

    thread_ctl #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_thr (
      .clk         (clk),
      .rst         (rst),
      .enable      (thread_enable[t]),
      .offered     (offer_vec[t]),
      .grant       (grant_vec[t]),
      .alu_sel     (alu_sel_vec[t]),
      .alu_pend    (alu_lsu_pend),
      .alu_illegal (alu_illegal),
      .alu_new_pc  (alu_new_pc),
      .lsu_rel     (lsu_rel_vec[t]),
      .ready       (t_ready[t]),
      .issued      (t_issued[t]),
      .halt        (t_halt[t]),
      .pc          (t_pc[t])
    );
  end

  assign halted = t_halt;

  // ---------------- round-robin fetch offer ----------------
  logic [TID_W-1:0]   last_tid, base_tid, nxt_tid;
  logic [THREADS-1:0] cand;
  logic               nxt_found;
  int                 idx;

  // The thread granted this edge is leaving READY, and a disabled READY
  // thread is about to go OFF, so neither may be offered next.
  assign cand     = t_ready & thread_enable & ~grant_vec;
  assign base_tid = grant ? fetch_tid : last_tid;

  always_comb begin
    nxt_found = 1'b0;
    nxt_tid   = '0;
    idx       = 0;
    for (int i = 1; i <= THREADS; i++) begin
      idx = (int'(base_tid) + i) % THREADS;
      if (!nxt_found && cand[TID_W'(idx)]) begin
        nxt_found = 1'b1;
        nxt_tid   = TID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_valid <= 1'b0;
      fetch_pc    <= '0;
      fetch_tid   <= '0;
      last_tid    <= TID_W'(THREADS - 1);   // first search starts at thread 0
    end else begin
      if (grant) last_tid <= fetch_tid;
      // A pending offer is held untouched until fetch takes it.
      if (!fetch_valid || grant) begin
        fetch_valid <= nxt_found;
        if (nxt_found) begin
          fetch_tid <= nxt_tid;
          fetch_pc  <= t_pc[nxt_tid];
        end
      end
    end
  end
endmodule

// File: tb/tb_thread_writeback.sv
module tb_thread_writeback;
  localparam int NT = 4;
  localparam int DEPTH = 2;
  localparam int S_OFF = 0, S_RDY = 1, S_ISS = 2, S_WAIT = 3, S_HALT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  thread_enable;
  logic        alu_valid, alu_rd_en, alu_lsu_pend, alu_illegal;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_rd_data;
  logic [1:0]  alu_tid;
  logic [28:0] alu_new_pc;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_rd_data;
  logic [1:0]  lsu_tid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  rf_wtid;
  logic        fetch_valid, fetch_ready;
  logic [28:0] fetch_pc;
  logic [1:0]  fetch_tid;
  logic [3:0]  halted;

  thread_writeback dut (
    .clk(clk), .rst(rst), .thread_enable(thread_enable),
    .alu_valid(alu_valid), .alu_rd_en(alu_rd_en), .alu_rd_addr(alu_rd_addr),
    .alu_rd_data(alu_rd_data), .alu_tid(alu_tid), .alu_new_pc(alu_new_pc),
    .alu_lsu_pend(alu_lsu_pend), .alu_illegal(alu_illegal),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr),
    .lsu_rd_data(lsu_rd_data), .lsu_tid(lsu_tid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wtid(rf_wtid),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_tid(fetch_tid), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; logic [31:0] data; logic [1:0] tid; } ent_t;
  int          st [NT];
  logic [28:0] pc [NT];
  ent_t        fifo [$];
  bit          m_we, m_fv;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_wtid, m_ftid, m_last;
  logic [28:0] m_fpc;

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin st[t] = S_OFF; pc[t] = '0; end
    fifo.delete();
    m_we = 0; m_waddr = '0; m_wdata = '0; m_wtid = 0;
    m_fv = 0; m_fpc = '0; m_ftid = 0; m_last = NT - 1;
  endtask

  // One clock edge of the specified behaviour, using the inputs now applied.
  task automatic model_step();
    bit grant, accept, claim, drain, enq, found;
    int gtid, base, nt;
    int nst [NT];
    bit cand [NT];
    ent_t head;
    grant  = m_fv && fetch_ready;
    gtid   = m_ftid;
    accept = alu_valid && (st[alu_tid] == S_ISS);
    claim  = accept && alu_rd_en && !alu_illegal && (alu_rd_addr != 0);
    drain  = (fifo.size() > 0) && !claim;
    enq    = lsu_valid && (fifo.size() < DEPTH);
    head   = '{rd: '0, data: '0, tid: '0};
    if (drain) head = fifo[0];
    if (claim) begin
      m_we = 1; m_waddr = alu_rd_addr; m_wdata = alu_rd_data; m_wtid = alu_tid;
    end else if (drain) begin
      m_we = (head.rd != 0); m_waddr = head.rd; m_wdata = head.data; m_wtid = head.tid;
    end else m_we = 0;
    for (int t = 0; t < NT; t++)
      cand[t] = (st[t] == S_RDY) && thread_enable[t] && !(grant && gtid == t);
    if (!m_fv || grant) begin
      base = grant ? gtid : m_last;
      found = 0;
      for (int i = 1; i <= NT; i++) begin
        nt = (base + i) % NT;
        if (!found && cand[nt]) begin found = 1; m_ftid = nt; m_fpc = pc[nt]; end
      end
      m_fv = found;
    end
    if (grant) m_last = gtid;
    for (int t = 0; t < NT; t++) begin
      nst[t] = st[t];
      if (st[t] == S_OFF && thread_enable[t]) nst[t] = S_RDY;
      if (st[t] == S_RDY) begin
        if (grant && gtid == t) nst[t] = S_ISS;
        else if (!thread_enable[t] && !(m_fv_prev_is(t, grant, gtid))) nst[t] = S_OFF;
      end
      if (st[t] == S_ISS && accept && alu_tid == t) begin
        if (alu_illegal) nst[t] = S_HALT;
        else begin
          pc[t]  = alu_new_pc;
          nst[t] = alu_lsu_pend ? S_WAIT : S_RDY;
        end
      end
      if (st[t] == S_WAIT && drain && head.tid == t) nst[t] = S_RDY;
    end
    for (int t = 0; t < NT; t++) st[t] = nst[t];
    if (drain) void'(fifo.pop_front());
    if (enq) fifo.push_back('{rd: lsu_rd_addr, data: lsu_rd_data, tid: lsu_tid});
  endtask

  // Offer held before this edge: valid unless it was taken (then gtid was offered).
  bit pre_fv; int pre_ftid;
  function automatic bit m_fv_prev_is(input int t, input bit grant, input int gtid);
    return (pre_fv && pre_ftid == t) || (grant && gtid == t);
  endfunction

  function automatic logic [3:0] m_halted();
    logic [3:0] h;
    for (int t = 0; t < NT; t++) h[t] = (st[t] == S_HALT);
    return h;
  endfunction

  task automatic chk_model();
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("rf_wtid", rf_wtid, m_wtid);
    end
    chk("fetch_valid", fetch_valid, m_fv);
    if (m_fv) begin
      chk("fetch_pc", fetch_pc, m_fpc);
      chk("fetch_tid", fetch_tid, m_ftid);
    end
    chk("halted", halted, m_halted());
    chk("lsu_ready", lsu_ready, fifo.size() < DEPTH);
  endtask

  task automatic step_model_edge();
    @(posedge clk);
    pre_fv = m_fv; pre_ftid = m_ftid;
    model_step();
    #1;
  endtask

  task automatic cycle();
    step_model_edge();
    chk_model();
  endtask

  task automatic clr_inputs();
    thread_enable = '0; fetch_ready = 0;
    alu_valid = 0; alu_rd_en = 0; alu_rd_addr = '0; alu_rd_data = '0; alu_tid = '0;
    alu_new_pc = '0; alu_lsu_pend = 0; alu_illegal = 0;
    lsu_valid = 0; lsu_rd_addr = '0; lsu_rd_data = '0; lsu_tid = '0;
  endtask

  task automatic clr_alu_lsu();
    alu_valid = 0; alu_rd_en = 0; alu_lsu_pend = 0; alu_illegal = 0; lsu_valid = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".rf_we"}, rf_we, 0);
    chk({tag, ".rf_waddr"}, rf_waddr, 0);
    chk({tag, ".rf_wdata"}, rf_wdata, 0);
    chk({tag, ".rf_wtid"}, rf_wtid, 0);
    chk({tag, ".fetch_valid"}, fetch_valid, 0);
    chk({tag, ".fetch_pc"}, fetch_pc, 0);
    chk({tag, ".fetch_tid"}, fetch_tid, 0);
    chk({tag, ".halted"}, halted, 0);
    chk({tag, ".lsu_ready"}, lsu_ready, 1);
  endtask

  task automatic do_reset();
    rst = 0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_reset("reset");
    @(negedge clk);
    rst = 1;
  endtask

  // Reset asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset_check(input string tag);
    #2;
    rst = 0;
    #1;
    chk_reset(tag);
    model_reset();
    clr_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  function automatic bit in_fifo(input int t);
    foreach (fifo[i]) if (fifo[i].tid == t) return 1;
    return 0;
  endfunction

  task automatic drive_random();
    int q [$];
    int k;
    clr_alu_lsu();
    if ($urandom_range(0, 15) == 0) begin
      k = $urandom_range(0, NT - 1);
      thread_enable[k] = ~thread_enable[k];
    end
    fetch_ready = ($urandom_range(0, 3) != 0);
    for (int t = 0; t < NT; t++) if (st[t] == S_ISS) q.push_back(t);
    if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
      alu_valid = 1;
      alu_tid   = 2'(q[$urandom_range(0, q.size() - 1)]);
    end else if ($urandom_range(0, 19) == 0) begin
      k = $urandom_range(0, NT - 1);
      if (st[k] != S_ISS) begin alu_valid = 1; alu_tid = 2'(k); end
    end
    alu_rd_en    = ($urandom_range(0, 3) != 0);
    alu_rd_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    alu_rd_data  = $urandom;
    alu_new_pc   = 29'($urandom);
    alu_lsu_pend = ($urandom_range(0, 3) == 0);
    alu_illegal  = ($urandom_range(0, 199) == 0);
    q.delete();
    for (int t = 0; t < NT; t++) if (st[t] == S_WAIT && !in_fifo(t)) q.push_back(t);
    if (q.size() > 0 && fifo.size() < DEPTH && $urandom_range(0, 1) == 1) begin
      lsu_valid   = 1;
      lsu_tid     = 2'(q[$urandom_range(0, q.size() - 1)]);
      lsu_rd_addr = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lsu_rd_data = $urandom;
    end
  endtask

  // ---------------- directed table (thread 0 only) ----------------
  typedef struct {
    logic        av, aen, apend, aill, lv;
    logic [4:0]  ard, lrd;
    logic [31:0] adata, ldata;
    logic [28:0] apc;
    logic        ewe, efv;
    logic [4:0]  ewaddr;
    logic [31:0] ewdata;
    logic [28:0] efpc;
    logic [3:0]  ehalt;
  } vec_t;

  function automatic vec_t mk(input logic av, aen, input logic [4:0] ard, input logic [31:0] adata,
                              input logic [28:0] apc, input logic apend, aill, lv,
                              input logic [4:0] lrd, input logic [31:0] ldata,
                              input logic ewe, input logic [4:0] ewaddr, input logic [31:0] ewdata,
                              input logic efv, input logic [28:0] efpc, input logic [3:0] ehalt);
    vec_t v;
    v.av = av; v.aen = aen; v.ard = ard; v.adata = adata; v.apc = apc; v.apend = apend;
    v.aill = aill; v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.ewe = ewe; v.ewaddr = ewaddr;
    v.ewdata = ewdata; v.efv = efv; v.efpc = efpc; v.ehalt = ehalt;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int granted [$];
    int seen_t1, n;
    bit hit;
    //            av aen rd  adata         apc     pnd ill lv lrd ldata        we wa  wdata         fv fpc     halt
    tbl[0]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[1]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 29'h0,  4'h0);
    tbl[2]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[3]  = mk(1, 1, 5,  32'h1234,     29'h4,  0, 0, 0, 0, 32'h0,        1, 5,  32'h1234,     0, 29'h0,  4'h0);
    tbl[4]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 29'h4,  4'h0);
    tbl[5]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[6]  = mk(1, 0, 7,  32'h0,        29'h8,  1, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[7]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[8]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 1, 7, 32'hDEAD,     0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[9]  = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        1, 7,  32'hDEAD,     0, 29'h0,  4'h0);
    tbl[10] = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 29'h8,  4'h0);
    tbl[11] = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[12] = mk(1, 1, 0,  32'hFFFFFFFF, 29'h10, 0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[13] = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 29'h10, 4'h0);
    tbl[14] = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h0);
    tbl[15] = mk(1, 1, 3,  32'h55,       29'h20, 0, 1, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h1);
    tbl[16] = mk(0, 0, 0,  32'h0,        29'h0,  0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h1);
    tbl[17] = mk(1, 1, 4,  32'h77,       29'h30, 0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        0, 29'h0,  4'h1);

    rst = 0;
    clr_inputs();
    pre_fv = 0; pre_ftid = 0;
    do_reset();

    for (int i = 0; i < 18; i++) begin
      thread_enable = 4'b0001; fetch_ready = 1;
      alu_valid = tbl[i].av; alu_rd_en = tbl[i].aen; alu_rd_addr = tbl[i].ard;
      alu_rd_data = tbl[i].adata; alu_tid = 2'd0; alu_new_pc = tbl[i].apc;
      alu_lsu_pend = tbl[i].apend; alu_illegal = tbl[i].aill;
      lsu_valid = tbl[i].lv; lsu_rd_addr = tbl[i].lrd; lsu_rd_data = tbl[i].ldata; lsu_tid = 2'd0;
      step_model_edge();
      chk($sformatf("t%0d.rf_we", i), rf_we, tbl[i].ewe);
      if (tbl[i].ewe) begin
        chk($sformatf("t%0d.rf_waddr", i), rf_waddr, tbl[i].ewaddr);
        chk($sformatf("t%0d.rf_wdata", i), rf_wdata, tbl[i].ewdata);
      end
      chk($sformatf("t%0d.fetch_valid", i), fetch_valid, tbl[i].efv);
      if (tbl[i].efv) begin
        chk($sformatf("t%0d.fetch_pc", i), fetch_pc, tbl[i].efpc);
        chk($sformatf("t%0d.fetch_tid", i), fetch_tid, 0);
      end
      chk($sformatf("t%0d.halted", i), halted, tbl[i].ehalt);
      chk($sformatf("t%0d.lsu_ready", i), lsu_ready, 1);
    end

    // ---- all threads: round-robin grants 0,1,2,3 then nothing until commits ----
    do_reset();
    thread_enable = 4'hF; fetch_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (fetch_valid) granted.push_back(int'(fetch_tid));
      cycle();
    end
    chk("rr.count", granted.size(), 4);
    for (int i = 0; i < granted.size() && i < 4; i++)
      chk($sformatf("rr.grant%0d", i), granted[i], i);

    // ---- ALU priority over LSU, FIFO fill, drain in first ALU-free cycle ----
    fetch_ready = 0;
    clr_alu_lsu(); alu_valid = 1; alu_tid = 0; alu_lsu_pend = 1; alu_new_pc = 29'h40; cycle();
    clr_alu_lsu(); alu_valid = 1; alu_tid = 1; alu_lsu_pend = 1; alu_new_pc = 29'h44; cycle();
    clr_alu_lsu(); alu_valid = 1; alu_tid = 2; alu_rd_en = 1; alu_rd_addr = 10; alu_rd_data = 32'hA0;
    alu_new_pc = 29'h48; lsu_valid = 1; lsu_tid = 0; lsu_rd_addr = 7; lsu_rd_data = 32'hDEAD; cycle();
    chk("pri.alu1_waddr", rf_waddr, 10);
    clr_alu_lsu(); alu_valid = 1; alu_tid = 3; alu_rd_en = 1; alu_rd_addr = 11; alu_rd_data = 32'hB0;
    alu_new_pc = 29'h4C; lsu_valid = 1; lsu_tid = 1; lsu_rd_addr = 8; lsu_rd_data = 32'hBEEF; cycle();
    chk("pri.alu2_waddr", rf_waddr, 11);
    chk("pri.full_ready", lsu_ready, 0);
    clr_alu_lsu(); lsu_valid = 1; lsu_tid = 3; lsu_rd_addr = 9; lsu_rd_data = 32'h999; cycle();
    chk("pri.drain1_we", rf_we, 1);
    chk("pri.drain1_data", rf_wdata, 32'hDEAD);
    clr_alu_lsu(); cycle();
    chk("pri.drain2_data", rf_wdata, 32'hBEEF);
    cycle();
    chk("pri.dropped_we", rf_we, 0);

    // ---- illegal on thread 1, then never offered; then async reset ----
    fetch_ready = 1;
    n = 0;
    while (st[1] != S_ISS && n < 20) begin cycle(); n++; end
    chk("ill.issue_wait", st[1] == S_ISS, 1);
    clr_alu_lsu(); alu_valid = 1; alu_tid = 1; alu_rd_en = 1; alu_rd_addr = 6;
    alu_rd_data = 32'h66; alu_new_pc = 29'h1FF; alu_illegal = 1; cycle();
    chk("ill.halted", halted, 4'b0010);
    chk("ill.no_write", rf_we, 0);
    seen_t1 = 0;
    for (int i = 0; i < 30; i++) begin
      clr_alu_lsu();
      hit = 0;
      for (int t = 0; t < NT; t++)
        if (!hit && st[t] == S_ISS) begin
          hit = 1; alu_valid = 1; alu_tid = 2'(t); alu_rd_en = 1;
          alu_rd_addr = 5'(t + 1); alu_rd_data = 32'(i); alu_new_pc = 29'(100 + i);
        end
      cycle();
      if (fetch_valid && fetch_tid == 2'd1) seen_t1++;
    end
    chk("ill.t1_never_offered", seen_t1, 0);
    async_reset_check("midrst");

    // ---- randomized segments, each ending with an async reset ----
    for (int seg = 0; seg < 3; seg++) begin
      thread_enable = 4'hF;
      for (int i = 0; i < 1000; i++) begin
        drive_random();
        cycle();
      end
      async_reset_check($sformatf("segrst%0d", seg));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
